mips_writeback: RTL and testbench
=================================

# mips_writeback

MEM/WB pipeline stage of the MIPS core and the producer side of the `register_file32` write port. It registers memory-stage results and extracts and sign-extends load data. It drives `RegWrite`/`write_register`/`write_data` into the register file. Optionally it bypasses the in-flight write onto the decode read ports so same-cycle reads return the new value.

## Interface
- `DATA_W`, 32, datapath width; only 32 is supported.
- `ADDR_W`, 5, register index width.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset.
- `stall`  in  1  hold the MEM/WB register.
- `flush`  in  1  insert a bubble.
- `mem_valid`  in  1  MEM stage holds a real instruction.
- `mem_RegWrite`  in  1  the instruction writes a register.
- `mem_MemtoReg`  in  2  write-data source: 00 ALU, 01 load, 10 link, 11 reserved.
- `mem_dest`  in  5  destination register index.
- `mem_alu_result`  in  32  ALU result; for loads, the effective address.
- `mem_load_data`  in  32  aligned word read from data memory.
- `mem_load_size`  in  2  load size: 00 byte, 01 half, 10 word, 11 reserved.
- `mem_load_unsigned`  in  1  zero-extend instead of sign-extend.
- `mem_link_addr`  in  32  PC+8 for JAL/JALR.
- `read_register1`, `read_register2`  in  5  decode read indices.
- `rf_data1`, `rf_data2`  in  32  raw register-file read data.
- `RegWrite`  out  1  register-file write enable.
- `write_register`  out  5  register-file write index.
- `write_data`  out  32  register-file write data.
- `read_data1`, `read_data2`  out  32  read data to decode, bypassed when the feature is enabled.
- `wb_misalign`  out  1  one-cycle pulse: misaligned load was dropped.
- `wb_count`  out  32  number of committed register writes.

## Operation
- The stage holds one register set: `valid`, `we`, `dest`, `data`, `misalign`. `RegWrite`, `write_register` and `write_data` are driven directly from these registers.
- **Capture.** Each edge with `stall`=0 and `flush`=0 loads the register set from the MEM inputs.
- **Write-data mux.** The mux is evaluated before capture.
  - ALU (00): `mem_alu_result`.
  - Link (10): `mem_link_addr`.
  - Reserved (11): 0, and the write is dropped.
- **Load extraction (big-endian).** Offset is `a = mem_alu_result[1:0]`.
  - Byte: lane `mem_load_data[31-8a -: 8]`.
  - Half: lane `[31-16a[1] -: 16]`.
  - Word: the whole word.
  - The lane is sign-extended, or zero-extended when `mem_load_unsigned`=1.
- **Misaligned load.** A half load with `a[0]`=1, or a word load with `a`≠0, clears `we` and sets `misalign`.
- **Write enable.** `we = mem_valid & mem_RegWrite & (mem_dest≠0) & ~misaligned & (mem_MemtoReg≠11)`.
- **Outputs.** `RegWrite = valid & we`. `wb_misalign = valid & misalign`.
- **Write counter.** `wb_count` increments on every edge where `RegWrite`=1 is presented to the register file. It wraps from FFFF_FFFF to 0.

## Timing
- **Reset.** Reset is asynchronous: all stage registers clear immediately.
  - `RegWrite`=0, `write_register`=0, `write_data`=0, `wb_misalign`=0, `wb_count`=0.
  - `read_data1`/`read_data2` equal `rf_data1`/`rf_data2`.
- **Latency.** One cycle: MEM inputs sampled at edge N appear on the write port after edge N. The register file commits them at edge N+1.
- **Stall.** `stall`=1 holds every stage register. `RegWrite` stays asserted, so the register file rewrites the same value, which is harmless. `wb_count` still increments on each such edge, because the count is of write strobes.
- **Flush.** `flush`=1 loads a bubble (`valid`=0, `we`=0, `misalign`=0; `dest`/`data` don't-care). Flush has priority over stall.
- **Reset mid-stall.** Reset returns the stage to a bubble. Nothing is replayed when reset is released.
- **Register $0.** Writes to register 0 never assert `RegWrite`, even when `mem_RegWrite`=1.

## Configuration
- **`MIPS_WB_BYPASS_EN` defined:** the read outputs are combinationally bypassed.
  - `read_data1 = (RegWrite && write_register==read_register1) ? write_data : rf_data1`.
  - `read_data2` is formed the same way from `read_register2` and `rf_data2`.
  - Index 0 never matches, because `RegWrite` is never asserted for register 0.
- **Undefined:** `read_data1`/`read_data2` pass `rf_data1`/`rf_data2` through unchanged, and decode must stall one extra cycle on a WB hazard.

## Test plan
- **Reset.** Assert `rst`=0 mid-cycle while `RegWrite`=1 → outputs clear without waiting for a clock edge; `wb_count`=0.
- **ALU write.** `mem_valid`=1, `mem_RegWrite`=1, `mem_dest`=19, `mem_MemtoReg`=00, `mem_alu_result`=6363_6363 → next cycle `RegWrite`=1, `write_register`=19, `write_data`=6363_6363; `wb_count`=1 after the following edge.
- **Signed byte load.** `mem_load_data`=1280_FF7F, `a`=1 → `write_data`=FFFF_FF80.
- **Unsigned half load.** Same data, `a`=2, unsigned → `write_data`=0000_FF7F.
- **Misaligned load.** Half load with `a`=3 → `RegWrite`=0, `wb_misalign` pulses for one cycle.
- **Destination $0.** `mem_dest`=0 → `RegWrite`=0.
- **Stall and flush.** Stall with `mem_alu_result` changing → `write_data` holds. `flush`=1 together with `stall`=1 → `RegWrite`=0 on the next cycle.
- **Bypass (`MIPS_WB_BYPASS_EN` defined).** Write 7777_7777 to register 9 with `read_register2`=9 and `rf_data2`=0 → `read_data2`=7777_7777 in the same cycle. Without the macro → `read_data2`=0.

Source files
------------

// File: rtl/mips_writeback.sv
// MEM/WB pipeline stage: registers memory-stage results, extracts big-endian load lanes
// and drives the register-file write port. Define MIPS_WB_BYPASS_EN to bypass writes onto decode reads.
module mips_writeback #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              mem_valid,
  input  logic              mem_RegWrite,
  input  logic [1:0]        mem_MemtoReg,
  input  logic [ADDR_W-1:0] mem_dest,
  input  logic [DATA_W-1:0] mem_alu_result,
  input  logic [DATA_W-1:0] mem_load_data,
  input  logic [1:0]        mem_load_size,
  input  logic              mem_load_unsigned,
  input  logic [DATA_W-1:0] mem_link_addr,
  input  logic [ADDR_W-1:0] read_register1,
  input  logic [ADDR_W-1:0] read_register2,
  input  logic [DATA_W-1:0] rf_data1,
  input  logic [DATA_W-1:0] rf_data2,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] write_register,
  output logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  output logic              wb_misalign,
  output logic [31:0]       wb_count
);

  logic              valid_q, we_q, misalign_q;
  logic [ADDR_W-1:0] dest_q;
  logic [DATA_W-1:0] data_q;
  logic [31:0]       count_q;

  logic              we_d, misalign_d;
  logic [DATA_W-1:0] data_d, load_d;
  logic [7:0]        byte_lane;
  logic [15:0]       half_lane;
  logic [1:0]        a;

  assign a = mem_alu_result[1:0];

  always_comb begin
    byte_lane = 8'h00;
    half_lane = 16'h0000;
    load_d    = '0;
    // Big-endian: offset 0 selects the most significant lane.
    case (a)
      2'd0:    byte_lane = mem_load_data[31:24];
      2'd1:    byte_lane = mem_load_data[23:16];
      2'd2:    byte_lane = mem_load_data[15:8];
      default: byte_lane = mem_load_data[7:0];
    endcase
    half_lane = a[1] ? mem_load_data[15:0] : mem_load_data[31:16];
    case (mem_load_size)
      2'b00:   load_d = {{(DATA_W-8){byte_lane[7] & ~mem_load_unsigned}}, byte_lane};
      2'b01:   load_d = {{(DATA_W-16){half_lane[15] & ~mem_load_unsigned}}, half_lane};
      default: load_d = mem_load_data;
    endcase
  end

  always_comb begin
    data_d     = '0;
    misalign_d = 1'b0;
    case (mem_MemtoReg)
      2'b00: data_d = mem_alu_result;
      2'b01: begin
        data_d = load_d;
        // Reserved size 11 is treated as a word access.
        misalign_d = ((mem_load_size == 2'b01) & a[0]) |
                     (mem_load_size[1] & (a != 2'b00));
      end
      2'b10:   data_d = mem_link_addr;
      default: data_d = '0;
    endcase
    we_d = mem_valid & mem_RegWrite & (mem_dest != '0) & ~misalign_d &
           (mem_MemtoReg != 2'b11);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q    <= 1'b0;
      we_q       <= 1'b0;
      misalign_q <= 1'b0;
      dest_q     <= '0;
      data_q     <= '0;
    end else if (flush) begin
      valid_q    <= 1'b0;
      we_q       <= 1'b0;
      misalign_q <= 1'b0;
    end else if (!stall) begin
      valid_q    <= mem_valid;
      we_q       <= we_d;
      misalign_q <= misalign_d;
      dest_q     <= mem_dest;
      data_q     <= data_d;
    end
  end

  // Counts write strobes, so a stalled write is counted on every edge it is held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else if (valid_q & we_q) begin
      count_q <= count_q + 32'd1;
    end
  end

  assign RegWrite       = valid_q & we_q;
  assign write_register = dest_q;
  assign write_data     = data_q;
  assign wb_misalign    = valid_q & misalign_q;
  assign wb_count       = count_q;

`ifdef MIPS_WB_BYPASS_EN
  assign read_data1 = (RegWrite && (write_register == read_register1)) ? write_data : rf_data1;
  assign read_data2 = (RegWrite && (write_register == read_register2)) ? write_data : rf_data2;
`else
  assign read_data1 = rf_data1;
  assign read_data2 = rf_data2;
`endif

endmodule

// File: tb/tb_mips_writeback.sv
// Directed bench for mips_writeback: vector table plus stall/flush, bypass and async-reset sequences.
module tb_mips_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, flush;
  logic        mem_valid, mem_RegWrite;
  logic [1:0]  mem_MemtoReg;
  logic [4:0]  mem_dest;
  logic [31:0] mem_alu_result, mem_load_data, mem_link_addr;
  logic [1:0]  mem_load_size;
  logic        mem_load_unsigned;
  logic [4:0]  read_register1, read_register2;
  logic [31:0] rf_data1, rf_data2;
  logic        RegWrite, wb_misalign;
  logic [4:0]  write_register;
  logic [31:0] write_data, read_data1, read_data2, wb_count;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_count = 32'd0;
  logic        exp_we_prev = 1'b0;

  always #5 clk = ~clk;

  mips_writeback dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .mem_valid(mem_valid), .mem_RegWrite(mem_RegWrite), .mem_MemtoReg(mem_MemtoReg),
    .mem_dest(mem_dest), .mem_alu_result(mem_alu_result), .mem_load_data(mem_load_data),
    .mem_load_size(mem_load_size), .mem_load_unsigned(mem_load_unsigned),
    .mem_link_addr(mem_link_addr), .read_register1(read_register1),
    .read_register2(read_register2), .rf_data1(rf_data1), .rf_data2(rf_data2),
    .RegWrite(RegWrite), .write_register(write_register), .write_data(write_data),
    .read_data1(read_data1), .read_data2(read_data2), .wb_misalign(wb_misalign),
    .wb_count(wb_count)
  );

  typedef struct {
    string       name;
    logic        valid;
    logic        rw;
    logic [1:0]  mtr;
    logic [4:0]  dest;
    logic [31:0] alu;
    logic [31:0] ld;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] link;
    logic        exp_we;
    logic        exp_mis;
    logic        chk_data;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Advance one edge, tracking the expected write-strobe count.
  task automatic step(input logic exp_we_now);
    @(posedge clk);
    if (exp_we_prev) exp_count = exp_count + 32'd1;
    exp_we_prev = exp_we_now;
    @(negedge clk);
  endtask

  task automatic drive(input vec_t v);
    mem_valid         = v.valid;
    mem_RegWrite      = v.rw;
    mem_MemtoReg      = v.mtr;
    mem_dest          = v.dest;
    mem_alu_result    = v.alu;
    mem_load_data     = v.ld;
    mem_load_size     = v.size;
    mem_load_unsigned = v.uns;
    mem_link_addr     = v.link;
  endtask

  initial begin
    vec_t w;
    vecs[0]  = '{"alu_r19",      1,1,2'b00,5'd19,32'h6363_6363,32'h0,        2'b10,0,32'h0,        1,0,1,32'h6363_6363};
    vecs[1]  = '{"lb_a1",        1,1,2'b01,5'd5, 32'h0000_1001,32'h1280_FF7F,2'b00,0,32'h0,        1,0,1,32'hFFFF_FF80};
    vecs[2]  = '{"lhu_a2",       1,1,2'b01,5'd6, 32'h0000_1002,32'h1280_FF7F,2'b01,1,32'h0,        1,0,1,32'h0000_FF7F};
    vecs[3]  = '{"lb_a2",        1,1,2'b01,5'd7, 32'h0000_1002,32'h1280_FF7F,2'b00,0,32'h0,        1,0,1,32'hFFFF_FFFF};
    vecs[4]  = '{"lb_a3",        1,1,2'b01,5'd8, 32'h0000_1003,32'h1280_FF7F,2'b00,0,32'h0,        1,0,1,32'h0000_007F};
    vecs[5]  = '{"lw_a0",        1,1,2'b01,5'd9, 32'h0000_1000,32'h1280_FF7F,2'b10,0,32'h0,        1,0,1,32'h1280_FF7F};
    vecs[6]  = '{"lh_misalign",  1,1,2'b01,5'd10,32'h0000_1003,32'h1280_FF7F,2'b01,0,32'h0,        0,1,0,32'h0};
    vecs[7]  = '{"lw_misalign",  1,1,2'b01,5'd11,32'h0000_1002,32'h1280_FF7F,2'b10,0,32'h0,        0,1,0,32'h0};
    vecs[8]  = '{"dest_zero",    1,1,2'b00,5'd0, 32'h1234_5678,32'h0,        2'b10,0,32'h0,        0,0,1,32'h1234_5678};
    vecs[9]  = '{"link_r31",     1,1,2'b10,5'd31,32'h0000_0044,32'h0,        2'b10,0,32'h0040_0008,1,0,1,32'h0040_0008};
    vecs[10] = '{"mtr_reserved", 1,1,2'b11,5'd12,32'hDEAD_BEEF,32'h0,        2'b10,0,32'h0,        0,0,1,32'h0};
    vecs[11] = '{"not_valid",    0,1,2'b00,5'd13,32'hAAAA_5555,32'h0,        2'b10,0,32'h0,        0,0,1,32'hAAAA_5555};
    vecs[12] = '{"lbu_a1",       1,1,2'b01,5'd14,32'h0000_2001,32'h1280_FF7F,2'b00,1,32'h0,        1,0,1,32'h0000_0080};
    vecs[13] = '{"lh_a0_neg",    1,1,2'b01,5'd15,32'h0000_2000,32'h8001_0000,2'b01,0,32'h0,        1,0,1,32'hFFFF_8001};

    rst = 1'b0; stall = 1'b0; flush = 1'b0;
    read_register1 = 5'd0; read_register2 = 5'd0;
    rf_data1 = 32'h0; rf_data2 = 32'h0;
    w = vecs[11];
    w.valid = 1'b0;
    drive(w);
    repeat (2) @(negedge clk);
    chk("reset_regwrite", {31'b0, RegWrite}, 32'd0);
    chk("reset_wdata", write_data, 32'd0);
    chk("reset_count", wb_count, 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 14; i++) begin
      drive(vecs[i]);
      step(vecs[i].exp_we);
      chk({vecs[i].name, "_we"}, {31'b0, RegWrite}, {31'b0, vecs[i].exp_we});
      chk({vecs[i].name, "_mis"}, {31'b0, wb_misalign}, {31'b0, vecs[i].exp_mis});
      chk({vecs[i].name, "_dest"}, {27'b0, write_register}, {27'b0, vecs[i].dest});
      if (vecs[i].chk_data) chk({vecs[i].name, "_data"}, write_data, vecs[i].exp_data);
      chk({vecs[i].name, "_count"}, wb_count, exp_count);
    end

    // Stall holds a committed write; count keeps rising with each held strobe.
    w = vecs[0]; w.dest = 5'd3; w.alu = 32'h1111_1111;
    drive(w);
    step(1'b1);
    stall = 1'b1;
    mem_alu_result = 32'h2222_2222;
    step(1'b1);
    mem_alu_result = 32'h3333_3333;
    step(1'b1);
    chk("stall_data", write_data, 32'h1111_1111);
    chk("stall_we", {31'b0, RegWrite}, 32'd1);
    chk("stall_count", wb_count, exp_count);
    flush = 1'b1;
    step(1'b0);
    chk("flush_over_stall_we", {31'b0, RegWrite}, 32'd0);
    chk("flush_count", wb_count, exp_count);
    flush = 1'b0; stall = 1'b0;

    // Misalign pulse lasts exactly one cycle.
    drive(vecs[6]);
    step(1'b0);
    chk("pulse_hi", {31'b0, wb_misalign}, 32'd1);
    drive(vecs[0]);
    step(1'b1);
    chk("pulse_lo", {31'b0, wb_misalign}, 32'd0);

    // Same-cycle read of an in-flight write.
    w = vecs[0]; w.dest = 5'd9; w.alu = 32'h7777_7777;
    drive(w);
    read_register1 = 5'd4; rf_data1 = 32'h0000_ABCD;
    read_register2 = 5'd9; rf_data2 = 32'h0;
    step(1'b1);
`ifdef MIPS_WB_BYPASS_EN
    chk("bypass_rd2", read_data2, 32'h7777_7777);
`else
    chk("bypass_rd2", read_data2, 32'h0);
`endif
    chk("nomatch_rd1", read_data1, 32'h0000_ABCD);

    // Asynchronous reset mid-cycle while RegWrite is high, no replay on release.
    chk("pre_reset_we", {31'b0, RegWrite}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_we", {31'b0, RegWrite}, 32'd0);
    chk("async_rst_dest", {27'b0, write_register}, 32'd0);
    chk("async_rst_data", write_data, 32'd0);
    chk("async_rst_count", wb_count, 32'd0);
    mem_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    exp_count = 32'd0; exp_we_prev = 1'b0;
    step(1'b0);
    chk("post_reset_we", {31'b0, RegWrite}, 32'd0);
    chk("post_reset_count", wb_count, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
